// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Purpose  : Reads back a multiplexed active-low 7-seg bus and recovers the
//            hex digits shown, delivering complete frames over valid/ready.
// Options  : define SEG7_SCAN_ERRCNT_EN to add the 8-bit err_count output.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    bad_pattern,
    output logic                    overrun
`ifdef SEG7_SCAN_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int SW = 7 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]         C_STABLE  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]         C_CNT_ONE = CW'(1);
    localparam logic [NUM_DIGITS-1:0] C_SEL_ONE = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [SW-1:0]             r_sample;
    logic [SW-1:0]             r_prev;
    logic [SW-1:0]             r_cap;
    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             w_cnt_nxt;
    logic                      w_cap_load;
    logic [4*NUM_DIGITS-1:0]   r_shadow;
    logic [NUM_DIGITS-1:0]     r_seen;
    logic [4*NUM_DIGITS-1:0]   r_frame;
    logic                      r_valid;
    logic                      r_bad;
    logic                      r_ovr;

    logic [NUM_DIGITS-1:0]     w_sel_act;
    logic                      w_onehot;
    logic                      w_same;
    logic [NUM_DIGITS-1:0]     w_cap_act;
    logic [4:0]                w_dec;
    logic                      w_legal;
    logic [3:0]                w_nib;
    logic                      w_do_cap;
    logic                      w_complete;
    logic                      w_load;

    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   f_decode = {1'b1, 4'h0};
            7'h79:   f_decode = {1'b1, 4'h1};
            7'h24:   f_decode = {1'b1, 4'h2};
            7'h30:   f_decode = {1'b1, 4'h3};
            7'h19:   f_decode = {1'b1, 4'h4};
            7'h12:   f_decode = {1'b1, 4'h5};
            7'h02:   f_decode = {1'b1, 4'h6};
            7'h78:   f_decode = {1'b1, 4'h7};
            7'h00:   f_decode = {1'b1, 4'h8};
            7'h18:   f_decode = {1'b1, 4'h9};
            7'h08:   f_decode = {1'b1, 4'hA};
            7'h03:   f_decode = {1'b1, 4'hB};
            7'h46:   f_decode = {1'b1, 4'hC};
            7'h21:   f_decode = {1'b1, 4'hD};
            7'h06:   f_decode = {1'b1, 4'hE};
            7'h0E:   f_decode = {1'b1, 4'hF};
            default: f_decode = 5'b0_0000;
        endcase
    endfunction

    assign w_sel_act  = ~r_sample[NUM_DIGITS-1:0];
    assign w_onehot   = (w_sel_act != '0) && ((w_sel_act & (w_sel_act - C_SEL_ONE)) == '0);
    assign w_same     = (r_sample == r_prev);
    assign w_cap_act  = ~r_cap[NUM_DIGITS-1:0];
    assign w_dec      = f_decode(r_cap[SW-1:NUM_DIGITS]);
    assign w_legal    = w_dec[4];
    assign w_nib      = w_dec[3:0];
    assign w_do_cap   = (r_state == S_CAPTURE);
    assign w_complete = &r_seen;
    assign w_load     = w_complete && (!r_valid || frame_ready);

    // Idle bus (segments dark, no digit selected) so the FSM starts clean.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sample <= '1;
            r_prev   <= '1;
        end else begin
            r_sample <= {seg_in, dig_sel_n};
            r_prev   <= r_sample;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cap   <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_cap_load) begin
                r_cap <= r_sample;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_onehot) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (!w_same) begin
                    if (w_onehot) begin
                        w_cnt_nxt = C_CNT_ONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    if (r_cnt < C_STABLE) begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                    // Count reaches the threshold on this edge: snapshot the stable sample.
                    if (r_cnt >= C_STABLE - C_CNT_ONE) begin
                        w_state_nxt = S_CAPTURE;
                        w_cap_load  = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_sample != r_cap) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_shadow <= '0;
            r_seen   <= '0;
            r_bad    <= 1'b0;
        end else begin
            r_bad <= w_do_cap && !w_legal;
            if (w_complete) begin
                r_seen <= '0;
            end else if (w_do_cap && w_legal) begin
                r_seen <= r_seen | w_cap_act;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_do_cap && w_legal && w_cap_act[i]) begin
                    r_shadow[4*i +: 4] <= w_nib;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_frame <= r_shadow;
                r_valid <= 1'b1;
            end else begin
                if (w_complete) begin
                    r_ovr <= 1'b1;
                end
                if (r_valid && frame_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

`ifdef SEG7_SCAN_ERRCNT_EN
    logic [7:0] r_err;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_err <= 8'h00;
        end else if (w_do_cap && !w_legal && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'h01;
        end
    end

    assign err_count = r_err;
`endif

    assign frame_data  = r_frame;
    assign frame_valid = r_valid;
    assign bad_pattern = r_bad;
    assign overrun     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_decoder
// Purpose  : Event-level reference model driving seg7_scan_decoder with
//            directed and random display scans.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 8;

    logic            clk;
    logic            resetN;
    logic [6:0]      seg_in;
    logic [ND-1:0]   dig_sel_n;
    logic [4*ND-1:0] frame_data;
    logic            frame_valid;
    logic            frame_ready;
    logic            bad_pattern;
    logic            overrun;
`ifdef SEG7_SCAN_ERRCNT_EN
    logic [7:0]      err_count;
`endif

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (S)
    ) u_dut (
        .clk         (clk),
        .resetN      (resetN),
        .seg_in      (seg_in),
        .dig_sel_n   (dig_sel_n),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .bad_pattern (bad_pattern),
        .overrun     (overrun)
`ifdef SEG7_SCAN_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0]      codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0]      m_nib  [ND];
    bit              m_seen [ND];
    logic [4*ND-1:0] exp_q [$];
    int              exp_bad;
    int              obs_bad;
    int              exp_err;
    bit              exp_ovr;
    int              ready_mode;
    logic [6+ND:0]   last_key;
    bit              prev_bad;
    int              n_checks;
    int              n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*ND-1:0] model_frame();
        logic [4*ND-1:0] f;
        f = '0;
        for (int i = 0; i < ND; i++) f[4*i +: 4] = m_nib[i];
        return f;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < ND; i++) begin
            m_nib[i]  = 4'h0;
            m_seen[i] = 1'b0;
        end
        exp_ovr = 1'b0;
        exp_err = 0;
    endtask

    // A held pattern is captured once if it lasts long enough and selects exactly one digit.
    task automatic run_event(input logic [6:0] seg, input logic [ND-1:0] sel, input int n);
        int  zeros;
        int  dig;
        int  code;
        bit  all_seen;
        if ({seg, sel} == last_key) begin
            dig_sel_n = '1;
            @(posedge clk); #1;
        end
        zeros = 0;
        dig   = 0;
        code  = -1;
        for (int i = 0; i < ND; i++) if (!sel[i]) begin zeros++; dig = i; end
        for (int k = 0; k < 16; k++) if (codes[k] == seg) code = k;
        if (n >= S + 6 && zeros == 1) begin
            if (code < 0) begin
                exp_bad++;
                exp_err++;
            end else begin
                m_nib[dig]  = 4'(code);
                m_seen[dig] = 1'b1;
                all_seen = 1'b1;
                for (int i = 0; i < ND; i++) if (!m_seen[i]) all_seen = 1'b0;
                if (all_seen) begin
                    if (exp_q.size() != 0) exp_ovr = 1'b1;
                    else exp_q.push_back(model_frame());
                    for (int i = 0; i < ND; i++) m_seen[i] = 1'b0;
                end
            end
        end
        seg_in    = seg;
        dig_sel_n = sel;
        last_key  = {seg, sel};
        repeat (n) begin
            @(posedge clk); #1;
            if (ready_mode == 2) frame_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic scan4(input int c0, input int c1, input int c2, input int c3);
        run_event(codes[c0], 4'b1110, S + 10);
        run_event(codes[c1], 4'b1101, S + 10);
        run_event(codes[c2], 4'b1011, S + 10);
        run_event(codes[c3], 4'b0111, S + 10);
    endtask

    task automatic phase_check();
        chk("bad_count", obs_bad, exp_bad);
        chk("overrun", {31'b0, overrun}, {31'b0, exp_ovr});
`ifdef SEG7_SCAN_ERRCNT_EN
        chk("err_count", {24'b0, err_count}, (exp_err > 255) ? 32'd255 : 32'(exp_err));
`endif
    endtask

    task automatic drain();
        ready_mode  = 1;
        frame_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("queue_drained", exp_q.size(), 0);
        chk("valid_after_drain", {31'b0, frame_valid}, 0);
    endtask

    always @(negedge clk) begin
        if (!resetN) begin
            prev_bad = 1'b0;
        end else begin
            if (bad_pattern) begin
                obs_bad++;
                chk("bad_pulse_width", {31'b0, prev_bad}, 0);
            end
            prev_bad = bad_pattern;
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) chk("unexpected_frame", {31'b0, frame_valid}, 0);
                else chk("frame_data", frame_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_bad    = 0;
        obs_bad    = 0;
        prev_bad   = 1'b0;
        ready_mode = 0;
        last_key   = '1;
        model_reset();
        resetN      = 1'b0;
        seg_in      = 7'h7F;
        dig_sel_n   = '1;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, frame_valid}, 0);
        chk("rst_data", frame_data, 0);
        chk("rst_bad", {31'b0, bad_pattern}, 0);
        chk("rst_overrun", {31'b0, overrun}, 0);
        resetN = 1'b1;
        @(posedge clk); #1;

        // Basic scan of 0,1,2,3
        ready_mode  = 1;
        frame_ready = 1'b1;
        scan4(0, 1, 2, 3);
        chk("t1_valid_dropped", {31'b0, frame_valid}, 0);
        phase_check();

        // Short F on digit0 must not capture; the 5 that follows does
        run_event(7'h0E, 4'b1110, S - 1);
        run_event(7'h12, 4'b1110, S + 10);
        run_event(codes[1], 4'b1101, S + 10);
        run_event(codes[2], 4'b1011, S + 10);
        run_event(codes[3], 4'b0111, S + 10);
        drain();

        // Illegal code on digit1
        run_event(7'h7F, 4'b1101, S + 10);
        phase_check();
`ifdef SEG7_SCAN_ERRCNT_EN
        for (int k = 0; k < 300; k++) run_event((k % 2 == 0) ? 7'h7E : 7'h7F, 4'b1101, S + 6);
        phase_check();
`endif

        // Two selects low: never captured even with an illegal code
        run_event(7'h7F, 4'b1100, 50);
        phase_check();
        drain();

        // Randomised scans with a random consumer
        ready_mode = 2;
        for (int e = 0; e < 250; e++) begin
            logic [6:0]    sg;
            logic [ND-1:0] sl;
            int            n;
            if ($urandom_range(0, 9) < 7) sl = ~(ND'(1) << $urandom_range(0, ND - 1));
            else sl = ND'($urandom);
            if ($urandom_range(0, 9) < 8) sg = codes[$urandom_range(0, 15)];
            else sg = 7'($urandom);
            if ($urandom_range(0, 3) != 0) n = $urandom_range(S + 6, S + 12);
            else n = $urandom_range(1, S - 1);
            run_event(sg, sl, n);
        end
        drain();
        phase_check();

        // Stalled consumer: second frame is dropped, first held
        ready_mode  = 0;
        frame_ready = 1'b0;
        scan4(4, 5, 6, 7);
        chk("t4_valid_held", {31'b0, frame_valid}, 1);
        chk("t4_first_frame", frame_data, exp_q[0]);
        scan4(8, 9, 10, 11);
        chk("t4_still_first", frame_data, exp_q[0]);
        phase_check();
        drain();

        // Asynchronous reset mid-settle with a frame pending
        ready_mode  = 0;
        frame_ready = 1'b0;
        scan4(12, 13, 14, 15);
        chk("t6_valid_before", {31'b0, frame_valid}, 1);
        seg_in    = codes[2];
        dig_sel_n = 4'b1110;
        last_key  = {codes[2], 4'b1110};
        repeat (4) @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        model_reset();
        chk("t6_valid_rst", {31'b0, frame_valid}, 0);
        chk("t6_data_rst", frame_data, 0);
        chk("t6_overrun_rst", {31'b0, overrun}, 0);
        chk("t6_bad_rst", {31'b0, bad_pattern}, 0);
`ifdef SEG7_SCAN_ERRCNT_EN
        chk("t6_err_rst", {24'b0, err_count}, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        resetN      = 1'b1;
        ready_mode  = 1;
        frame_ready = 1'b1;
        last_key    = '1;
        scan4(9, 7, 3, 1);
        drain();
        phase_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
